// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D RAM port arbiter.
package mem_arbiter_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IACC,
      ARB_DACC,
      ARB_DONE
   } arb_state_t;

   localparam word_t ARB_BADDATA = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Saturating access timer: counts cycles while en is high, expires on the TIMEOUT-th one.
module mem_arbiter_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != CW'(TIMEOUT))) begin
         count_q <= count_q + 1'b1;
      end
   end

   // count_q holds the number of cycles already spent, so this flags the TIMEOUT-th cycle
   assign expired = en && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data load/store,
// with D-streak limiting to avoid fetch starvation and a bounded RAM wait.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_DSTREAK = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dhit,
   output logic              ram_REN,
   output logic              ram_WEN,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              err
);

   localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

   arb_state_t        state_q, state_d;
   logic              owner_d_q;
   logic              op_wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] store_q;
   logic [SW-1:0]     dstreak_q;
   logic              err_q;
   logic [DATA_W-1:0] iload_q, dload_q;

   logic              in_acc;
   logic              expired;
   logic              forced_i;
   logic              grant_d;
   logic              acc_end;
   logic [DATA_W-1:0] done_data;

   assign in_acc   = (state_q == ARB_IACC) || (state_q == ARB_DACC);
   assign forced_i = iREN && (dstreak_q == SW'(MAX_DSTREAK));
   assign grant_d  = (dREN || dWEN) && !forced_i;
   assign acc_end  = in_acc && (ram_ready || expired);

   // Ready wins over a simultaneous timeout; writes return no data.
   always_comb begin
      done_data = '0;
      if (!ram_ready) begin
         done_data = DATA_W'(ARB_BADDATA);
      end else if (!op_wr_q) begin
         done_data = ram_load;
      end
   end

   mem_arbiter_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .CLK     (CLK),
      .nRST    (nRST),
      .clr     (!in_acc),
      .en      (in_acc),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               state_d = ARB_DACC;
            end else if (iREN) begin
               state_d = ARB_IACC;
            end
         end
         ARB_IACC, ARB_DACC: begin
            if (ram_ready || expired) begin
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= ARB_IDLE;
         owner_d_q <= 1'b0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         store_q   <= '0;
         dstreak_q <= '0;
         err_q     <= 1'b0;
         iload_q   <= '0;
         dload_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARB_IDLE) begin
            if (grant_d) begin
               owner_d_q <= 1'b1;
               op_wr_q   <= dWEN;
               addr_q    <= daddr;
               store_q   <= dstore;
               if (!iREN) begin
                  dstreak_q <= '0;
               end else if (dstreak_q != SW'(MAX_DSTREAK)) begin
                  dstreak_q <= dstreak_q + 1'b1;
               end
            end else if (iREN) begin
               owner_d_q <= 1'b0;
               op_wr_q   <= 1'b0;
               addr_q    <= iaddr;
               store_q   <= '0;
               dstreak_q <= '0;
            end
         end
         if (acc_end) begin
            err_q <= !ram_ready;
            if (owner_d_q) begin
               dload_q <= done_data;
            end else begin
               iload_q <= done_data;
            end
         end
      end
   end

   assign ram_REN   = (state_q == ARB_IACC) || ((state_q == ARB_DACC) && !op_wr_q);
   assign ram_WEN   = (state_q == ARB_DACC) && op_wr_q;
   assign ram_addr  = addr_q;
   assign ram_store = store_q;
   assign ihit      = (state_q == ARB_DONE) && !owner_d_q;
   assign dhit      = (state_q == ARB_DONE) && owner_d_q;
   assign err       = (state_q == ARB_DONE) && err_q;
   assign iload     = iload_q;
   assign dload     = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM responder model plus a hit scoreboard.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic [31:0] iload, dload;
   logic        ihit, dhit;
   logic        ram_REN, ram_WEN;
   logic [31:0] ram_addr, ram_store, ram_load;
   logic        ram_ready;
   logic        err;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   acc_cnt = 0;
   int   lat = 1;
   int   ren_cycles = 0;
   int   wen_cycles = 0;
   logic keep_i = 1'b0;
   logic keep_d = 1'b0;

   always #5 CLK = ~CLK;

   mem_arbiter dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iload     (iload),
      .ihit      (ihit),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dload     (dload),
      .dhit      (dhit),
      .ram_REN   (ram_REN),
      .ram_WEN   (ram_WEN),
      .ram_addr  (ram_addr),
      .ram_store (ram_store),
      .ram_load  (ram_load),
      .ram_ready (ram_ready),
      .err       (err)
   );

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_d, input logic [31:0] data, input logic e);
      exp_t x;
      x.is_d = is_d;
      x.data = data;
      x.err  = e;
      sb.push_back(x);
   endtask

   // One clock: RAM responder (ready on the lat-th access cycle, lat=0 never) and hit monitor.
   task automatic tick();
      exp_t e;
      @(posedge CLK);
      #1;
      if (ram_REN || ram_WEN) begin
         acc_cnt++;
         if (ram_REN) ren_cycles++;
         if (ram_WEN) wen_cycles++;
      end else begin
         acc_cnt = 0;
      end
      ram_ready = (ram_REN || ram_WEN) && (lat != 0) && (acc_cnt == lat);
      ram_load  = ram_word(ram_addr);
      if (ihit || dhit) begin
         check("hit_overlap", {31'b0, ihit & dhit}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_hit", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("hit_owner", {31'b0, dhit}, {31'b0, e.is_d});
            check("hit_data", dhit ? dload : iload, e.data);
            check("hit_err", {31'b0, err}, {31'b0, e.err});
         end
         if (ihit && !keep_i) iREN = 1'b0;
         if (dhit && !keep_d) begin
            dREN = 1'b0;
            dWEN = 1'b0;
         end
      end else if (err) begin
         check("stray_err", {31'b0, err}, 32'd0);
      end
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", sb.size(), 32'd0);
   endtask

   initial begin
      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ram_load = '0; ram_ready = 1'b0;

      // reset state
      tick();
      tick();
      check("rst_ihit", {31'b0, ihit}, 32'd0);
      check("rst_dhit", {31'b0, dhit}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_ren", {31'b0, ram_REN}, 32'd0);
      check("rst_wen", {31'b0, ram_WEN}, 32'd0);
      check("rst_addr", ram_addr, 32'd0);
      check("rst_store", ram_store, 32'd0);
      check("rst_iload", iload, 32'd0);
      check("rst_dload", dload, 32'd0);
      nRST = 1'b1;
      tick();

      // 1: minimum-latency fetch
      lat = 1; ren_cycles = 0;
      iaddr = 32'h40; iREN = 1'b1;
      push(1'b0, 32'h1234, 1'b0);
      tick();
      check("t1_ren_c1", {31'b0, ram_REN}, 32'd1);
      check("t1_addr_c1", ram_addr, 32'h40);
      check("t1_ihit_c1", {31'b0, ihit}, 32'd0);
      tick();
      check("t1_ihit_c2", {31'b0, ihit}, 32'd1);
      check("t1_ren_c2", {31'b0, ram_REN}, 32'd0);
      tick();
      check("t1_ihit_c3", {31'b0, ihit}, 32'd0);
      check("t1_iload_hold", iload, 32'h1234);
      check("t1_ren_cycles", ren_cycles, 32'd1);
      check("t1_sb_empty", sb.size(), 32'd0);

      // 2: simultaneous I and D -> D first, then I
      lat = 2;
      iaddr = 32'h200; daddr = 32'h300;
      iREN = 1'b1; dREN = 1'b1;
      push(1'b1, ram_word(32'h300), 1'b0);
      push(1'b0, ram_word(32'h200), 1'b0);
      wait_empty(50);
      tick();

      // 4: multi-cycle write, request changes after grant are ignored
      lat = 3; wen_cycles = 0;
      daddr = 32'h80; dstore = 32'hCAFE; dWEN = 1'b1;
      push(1'b1, 32'h0, 1'b0);
      tick();
      check("t4_wen", {31'b0, ram_WEN}, 32'd1);
      check("t4_addr", ram_addr, 32'h80);
      check("t4_store", ram_store, 32'hCAFE);
      daddr = 32'h99; dstore = 32'h0;
      tick();
      check("t4_addr_latched", ram_addr, 32'h80);
      check("t4_store_latched", ram_store, 32'hCAFE);
      wait_empty(20);
      check("t4_wen_cycles", wen_cycles, 32'd3);
      tick();

      // 3: streak limit, 4 D grants then 1 I grant, twice
      lat = 1; keep_i = 1'b1; keep_d = 1'b1;
      iaddr = 32'h44; daddr = 32'h88; dstore = 32'h77;
      iREN = 1'b1; dWEN = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(1'b1, 32'h0, 1'b0);
         push(1'b0, ram_word(32'h44), 1'b0);
      end
      wait_empty(200);
      iREN = 1'b0; dWEN = 1'b0; keep_i = 1'b0; keep_d = 1'b0;
      tick();
      tick();
      check("t3_idle_ren", {31'b0, ram_REN}, 32'd0);
      check("t3_idle_wen", {31'b0, ram_WEN}, 32'd0);

      // 5a: RAM never ready -> timeout after 255 access cycles
      lat = 0; ren_cycles = 0;
      iaddr = 32'h100; iREN = 1'b1;
      push(1'b0, 32'hBAD1BAD1, 1'b1);
      wait_empty(300);
      check("t5_to_cycles", ren_cycles, 32'd255);
      tick();
      check("t5_idle_ren", {31'b0, ram_REN}, 32'd0);

      // 5b: ready on the 255th cycle wins over the timeout
      lat = 255; ren_cycles = 0;
      iREN = 1'b1;
      push(1'b0, ram_word(32'h100), 1'b0);
      wait_empty(300);
      check("t5_ready_cycles", ren_cycles, 32'd255);
      tick();

      // 6: reset during a D write aborts it silently
      lat = 0;
      daddr = 32'h500; dstore = 32'h1; dWEN = 1'b1;
      tick();
      tick();
      check("t6_wen_before", {31'b0, ram_WEN}, 32'd1);
      nRST = 1'b0;
      tick();
      check("t6_wen_after", {31'b0, ram_WEN}, 32'd0);
      check("t6_dhit_after", {31'b0, dhit}, 32'd0);
      nRST = 1'b1; dWEN = 1'b0;
      tick();
      check("t6_idle_wen", {31'b0, ram_WEN}, 32'd0);
      check("t6_no_dhit", {31'b0, dhit}, 32'd0);
      lat = 2;
      iaddr = 32'h600; iREN = 1'b1;
      push(1'b0, ram_word(32'h600), 1'b0);
      wait_empty(20);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
